// File: rtl/di_i2_alloc_ctrl.sv
// Issue-2 allocation controller: claims eligible instructions from primary IF,
// buffers them for issue-2 ID, caps in-flight ops, and sequences flush/drain.
module di_i2_alloc_ctrl #(
    parameter int DEPTH   = 2,
    parameter int MAX_OUT = 4,
    parameter int HOLDOFF = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        primary_if_valid,
    input  logic [31:0] pi_fetch_addr,
    input  logic [31:0] pi_instr_decomp,
    input  logic        pi_hwlp_di_prevent_cond,
    input  logic        i2_eligible,
    input  logic        flush,
    input  logic        drain_req,
    input  logic        i2_ready,
    input  logic        i2_done,
    output logic        i2_instr_allocated,
    output logic        i2_valid,
    output logic [31:0] i2_addr,
    output logic [31:0] i2_instr,
    output logic [3:0]  i2_outstanding,
    output logic        drained,
    output logic [1:0]  state
);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        HOLD  = 2'd1,
        DRAIN = 2'd2
    } st_t;

    localparam logic [1:0] LAST_PTR = 2'(DEPTH - 1);
    localparam logic [2:0] DEP_CNT  = 3'(DEPTH);
    localparam logic [4:0] MAX_SUM  = 5'(MAX_OUT);
    localparam logic [3:0] HOLD_LD  = 4'(HOLDOFF - 1);

    st_t         r_st;
    logic [3:0]  r_hold;
    logic [2:0]  r_cnt;
    logic [1:0]  r_rd;
    logic [1:0]  r_wr;
    logic [3:0]  r_out;
    logic        r_drn;
    logic [31:0] r_mem_a [4];
    logic [31:0] r_mem_i [4];

    logic [4:0]  w_sum;
    logic        w_alloc;
    logic        w_acc;
    logic        w_dec;

    function automatic logic [1:0] f_nxt(input logic [1:0] p);
        f_nxt = (p == LAST_PTR) ? 2'd0 : p + 2'd1;
    endfunction

    assign w_sum   = {2'b00, r_cnt} + {1'b0, r_out};
    assign w_alloc = primary_if_valid & i2_eligible & ~pi_hwlp_di_prevent_cond
                   & ~flush & (r_st == RUN) & ~drain_req
                   & (r_cnt < DEP_CNT) & (w_sum < MAX_SUM);
    assign i2_valid = (r_cnt != 3'd0) & ~flush;
    assign w_acc    = i2_valid & i2_ready;
    // a retire with nothing in flight is dropped so the count cannot wrap
    assign w_dec    = i2_done & (r_out != 4'd0);

    assign i2_instr_allocated = w_alloc;
    assign i2_addr        = r_mem_a[r_rd];
    assign i2_instr       = r_mem_i[r_rd];
    assign i2_outstanding = r_out;
    assign drained        = r_drn & drain_req;
    assign state          = r_st;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
            r_rd  <= '0;
            r_wr  <= '0;
            for (int i = 0; i < 4; i++) begin
                r_mem_a[i] <= '0;
                r_mem_i[i] <= '0;
            end
        end else if (flush) begin
            r_cnt <= '0;
            r_rd  <= '0;
            r_wr  <= '0;
        end else begin
            if (w_alloc) begin
                r_mem_a[r_wr] <= pi_fetch_addr;
                r_mem_i[r_wr] <= pi_instr_decomp;
                r_wr          <= f_nxt(r_wr);
            end
            if (w_acc)
                r_rd <= f_nxt(r_rd);
            if (w_alloc & ~w_acc)
                r_cnt <= r_cnt + 3'd1;
            else if (~w_alloc & w_acc)
                r_cnt <= r_cnt - 3'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_out <= '0;
        else if (w_acc & ~w_dec)
            r_out <= r_out + 4'd1;
        else if (~w_acc & w_dec)
            r_out <= r_out - 4'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_st   <= RUN;
            r_hold <= '0;
            r_drn  <= 1'b0;
        end else if (flush) begin
            r_st   <= HOLD;
            r_hold <= HOLD_LD;
            r_drn  <= 1'b0;
        end else begin
            case (r_st)
                RUN: begin
                    r_drn <= 1'b0;
                    if (drain_req)
                        r_st <= DRAIN;
                end
                HOLD: begin
                    r_drn <= 1'b0;
                    if (r_hold == 4'd0)
                        r_st <= drain_req ? DRAIN : RUN;
                    else
                        r_hold <= r_hold - 4'd1;
                end
                DRAIN: begin
                    r_drn <= drain_req & (r_cnt == 3'd0) & (r_out == 4'd0);
                    if (!drain_req)
                        r_st <= RUN;
                end
                default: begin
                    r_st  <= RUN;
                    r_drn <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/di_i2_alloc_ctrl.md
# di_i2_alloc_ctrl

Issue-2 allocation controller for the dual-issue front end. It sits between the primary IF stage and the issue-2 ID stage. Each cycle it decides whether the instruction presented by primary IF is claimed by issue 2, and it buffers claimed instructions in a small FIFO for issue-2 ID. It limits the number of in-flight issue-2 operations, and it sequences flush hold-off and drain requests.

## Interface
Parameters:
- DEPTH, 2, candidate FIFO entries (1..4)
- MAX_OUT, 4, max issue-2 ops buffered plus in flight (DEPTH..15)
- HOLDOFF, 2, cycles with allocation blocked after a flush (1..15)

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- primary_if_valid  in  1  primary IF presents a valid instruction
- pi_fetch_addr  in  32  address of presented instruction
- pi_instr_decomp  in  32  decompressed presented instruction
- pi_hwlp_di_prevent_cond  in  1  hwloop condition forbids issue-2 allocation
- i2_eligible  in  1  presented instruction is of an issue-2 executable class
- flush  in  1  branch/exception flush of front end
- drain_req  in  1  request to quiesce issue 2 (debug/CSR)
- i2_ready  in  1  issue-2 ID accepts FIFO head
- i2_done  in  1  one issue-2 op retired
- i2_instr_allocated  out  1  combinational claim of presented instruction
- i2_valid  out  1  FIFO head valid
- i2_addr  out  32  FIFO head address
- i2_instr  out  32  FIFO head instruction
- i2_outstanding  out  4  accepted-not-retired count
- drained  out  1  issue 2 fully quiescent under drain_req
- state  out  2  FSM state (RUN=0, HOLD=1, DRAIN=2)

## Operation
- The FSM has three states: RUN, HOLD, DRAIN. Reset state is RUN. Reset clears the FIFO, all counters and drained. Reset value of every output is 0.
- alloc = primary_if_valid & i2_eligible & !pi_hwlp_di_prevent_cond & !flush & state==RUN & !drain_req & fifo_cnt<DEPTH & (fifo_cnt+i2_outstanding)<MAX_OUT.
- i2_instr_allocated = alloc. It is purely combinational. alloc pushes {pi_fetch_addr, pi_instr_decomp} into the FIFO.
- A full FIFO blocks allocation even if a pop happens in the same cycle.
- i2_valid = fifo_cnt!=0 & !flush.
- Accept = i2_valid & i2_ready. Accept pops the head and increments i2_outstanding.
- i2_done decrements i2_outstanding. Accept and done in the same cycle leave the count unchanged. i2_done at count 0 is ignored (count saturates at 0).
- Flush has priority over everything else:
  - FIFO empties next cycle.
  - No push or pop occurs.
  - The FSM enters HOLD with holdoff counter = HOLDOFF-1.
  - i2_outstanding is unaffected; in-flight ops still retire.
  - Flush while already in HOLD reloads the counter.
  - Flush in DRAIN also goes to HOLD.
- HOLD decrements the counter each cycle. At 0 it exits to DRAIN if drain_req, else to RUN.
- drain_req in RUN moves the FSM to DRAIN next cycle; allocation stops in the same cycle through the alloc term. The FIFO keeps presenting entries to issue 2.
- DRAIN: drained = (fifo_cnt==0 & i2_outstanding==0), registered. drained deasserts with drain_req. The FSM returns to RUN the cycle after drain_req falls.
- Counter widths: fifo_cnt holds 0..DEPTH; i2_outstanding is 4 bits. The sum compare is done at 5 bits with no wrap.

## Timing
- Claim decision is made in cycle N. The entry is visible on i2_valid/i2_addr/i2_instr in N+1. There is no same-cycle bypass.
- FIFO head outputs are registered. i2_addr/i2_instr hold stable while i2_valid & !i2_ready.
- Flush in cycle N:
  - i2_valid=0 in N.
  - i2_instr_allocated=0 in N through N+HOLDOFF.
  - The first possible claim is in N+HOLDOFF+1.
- drained rises no earlier than one cycle after the last i2_done that reaches a count of 0.
- Asserting rst_n low mid-operation immediately clears all state, with no retirement bookkeeping.

## Test plan
- Back-to-back eligible instructions, i2_ready=1, i2_done=1 two cycles after each accept:
  - every instruction is claimed;
  - i2_valid follows one cycle later with matching addr/instr;
  - i2_outstanding stays at or below 2.
- i2_ready=0 with 4 eligible instructions:
  - two are claimed and the third/fourth are not, with i2_instr_allocated=0 (FIFO full, DEPTH=2);
  - head holds 0x80 until ready.
- i2_ready=1 and i2_done=0 for 6 eligible instructions:
  - claims stop when fifo_cnt+i2_outstanding=4;
  - a single i2_done re-enables exactly one claim.
- Flush with 2 entries queued and i2_outstanding=1:
  - FIFO is empty next cycle;
  - no claims for HOLDOFF=2 cycles after the flush;
  - i2_outstanding stays at 1 until i2_done.
- drain_req with 1 queued and 1 outstanding:
  - drained=1 only after the pop and two i2_done pulses;
  - drain_req low returns state to 0 next cycle.
- pi_hwlp_di_prevent_cond=1 or i2_eligible=0 on a valid instruction: i2_instr_allocated=0 and the FIFO is unchanged.
